// File: rtl/mux_arb_reg.sv
// mux_arb_reg: selects one of NUM_IN channels, either by the sel port or by
// round-robin arbitration. The selected word is held in a one-deep output
// register with a valid/ready handshake. The register refills in the same
// cycle it drains, so a stalling consumer never loses a word and a flowing
// consumer sees no bubbles.
module mux_arb_reg #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_f,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    localparam logic [SEL_W:0]   LP_NUM_IN = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LP_LAST   = SEL_W'(NUM_IN-1);

    // Output register and arbitration pointer
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_out_src;
    logic [SEL_W-1:0]  r_rr_ptr;

    // Combinational selection
    logic [SEL_W-1:0]  w_chosen;
    logic [SEL_W-1:0]  w_grant;
    logic              w_grant_vld;
    logic [SEL_W-1:0]  w_rr_next;
    logic [SEL_W-1:0]  w_src;
    logic              w_req;
    logic              w_ready_en;
    logic              w_load_en;
    logic              w_xfer;
    logic [NUM_IN-1:0] w_in_ready;
    logic [WIDTH-1:0]  w_sel_data;

    // Channel index base+k, wrapped modulo NUM_IN (base is always < NUM_IN).
    function automatic logic [SEL_W-1:0] f_wrap_idx(input logic [SEL_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_IN) begin
            s = s - NUM_IN;
        end
        return SEL_W'(s);
    endfunction

    // Directed choice: an out-of-range sel falls back to the last channel.
    always_comb begin
        if ({1'b0, sel} >= LP_NUM_IN) begin
            w_chosen = LP_LAST;
        end else begin
            w_chosen = sel;
        end
    end

    // Round-robin scan starting at r_rr_ptr; the descending loop lets the
    // nearest requester (smallest offset) win by being assigned last.
    always_comb begin
        w_grant     = {SEL_W{1'b0}};
        w_grant_vld = 1'b0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (in_valid[f_wrap_idx(r_rr_ptr, k)]) begin
                w_grant     = f_wrap_idx(r_rr_ptr, k);
                w_grant_vld = 1'b1;
            end else begin
                w_grant     = w_grant;
                w_grant_vld = w_grant_vld;
            end
        end
    end

    // Pointer moves to the channel just after the one granted.
    always_comb begin
        if (w_grant == LP_LAST) begin
            w_rr_next = {SEL_W{1'b0}};
        end else begin
            w_rr_next = w_grant + SEL_W'(1);
        end
    end

    // Handshake: source selection, per-channel ready and transfer strobe.
    // in_ready is built only from control signals, never from in_data.
    always_comb begin
        w_load_en = !r_out_valid || out_ready;
        if (mode == 1'b0) begin
            w_src      = w_chosen;
            w_req      = in_valid[w_chosen];
            w_ready_en = 1'b1;
        end else begin
            w_src      = w_grant;
            w_req      = w_grant_vld;
            w_ready_en = w_grant_vld;
        end
        w_in_ready = {NUM_IN{1'b0}};
        if (w_ready_en && w_load_en) begin
            w_in_ready[w_src] = 1'b1;
        end else begin
            w_in_ready = {NUM_IN{1'b0}};
        end
        w_xfer     = w_req && w_load_en;
        w_sel_data = in_data[int'(w_src)*WIDTH +: WIDTH];
    end

    // Output register: load on transfer, clear valid on drain, else hold.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_out_data  <= {WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_out_src   <= {SEL_W{1'b0}};
            r_rr_ptr    <= {SEL_W{1'b0}};
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_sel_data;
                r_out_src   <= w_src;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
            if (w_xfer && mode) begin
                r_rr_ptr <= w_rr_next;
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Scoreboard bench for mux_arb_reg: stimulus pushes expected {src,data}
// words into a queue; a monitor pops and compares every word the consumer
// takes. Direct checks cover reset, stalls and in_ready.
module tb_mux_arb_reg;

    logic        clk;
    logic        rst_f;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] ch [3];
    logic [47:0] in_data;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_src;

    int errors = 0;
    int checks = 0;
    logic [17:0] exp_q [$];

    assign in_data = {ch[2], ch[1], ch[0]};

    mux_arb_reg #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] src, input logic [15:0] d);
        exp_q.push_back({src, d});
    endtask

    // Monitor: every word the consumer takes must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_f && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got src=%0d data=%0h expected none", out_src, out_data);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                chk("sb_data", 32'(out_data), 32'(e[15:0]));
                chk("sb_src", 32'(out_src), 32'(e[17:16]));
            end
        end
    end

    initial begin
        logic [15:0] vals [3];
        rst_f = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 3'b000; out_ready = 1'b0;
        ch[0] = 16'h0000; ch[1] = 16'h0000; ch[2] = 16'h0000;
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        repeat (3) step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        rst_f = 1'b1;
        step();

        // Load a word (moves rr_ptr to 2), stall, then reset mid-cycle.
        mode = 1'b1; ch[1] = 16'hA5A5; in_valid = 3'b010; out_ready = 1'b0;
        #1 chk("t1_ready", 32'(in_ready), 32'b010);
        step();
        in_valid = 3'b000;
        chk("t1_loaded_valid", 32'(out_valid), 32'd1);
        chk("t1_loaded_data", 32'(out_data), 32'hA5A5);
        #2 rst_f = 1'b0;
        #1;
        chk("t1_async_valid", 32'(out_valid), 32'd0);
        chk("t1_async_data", 32'(out_data), 32'd0);
        chk("t1_async_src", 32'(out_src), 32'd0);
        step();
        rst_f = 1'b1;

        // Idle after reset: nothing requested.
        mode = 1'b1; in_valid = 3'b000; out_ready = 1'b1;
        #1 chk("idle_ready", 32'(in_ready), 32'b000);
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_data", 32'(out_data), 32'd0);

        // Directed select, including out-of-range sel=3.
        mode = 1'b0; ch[0] = vals[0]; ch[1] = vals[1]; ch[2] = vals[2];
        in_valid = 3'b111; out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            int c;
            c = (s > 2) ? 2 : s;
            sel = 2'(s);
            push(2'(c), vals[c]);
            #1 chk("t2_ready", 32'(in_ready), 32'(1 << c));
            step();
        end
        in_valid = 3'b000;
        step();
        chk("t2_drained", 32'(out_valid), 32'd0);

        // Backpressure with channel and sel changes while stalled.
        sel = 2'd1; ch[1] = 16'hBEEF; in_valid = 3'b010; out_ready = 1'b1;
        push(2'd1, 16'hBEEF);
        step();
        out_ready = 1'b0; ch[1] = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            sel = (i == 1) ? 2'd2 : 2'd1;
            #1;
            chk("t3_stall_ready", 32'(in_ready), 32'b000);
            chk("t3_stall_data", 32'(out_data), 32'hBEEF);
            chk("t3_stall_valid", 32'(out_valid), 32'd1);
            step();
        end
        sel = 2'd1; out_ready = 1'b1;
        push(2'd1, 16'h0001);
        #1 chk("t3_release_ready", 32'(in_ready), 32'b010);
        step();
        chk("t6_refill_valid", 32'(out_valid), 32'd1);
        chk("t6_refill_data", 32'(out_data), 32'h0001);
        in_valid = 3'b000;
        step();
        chk("t6_drain_valid", 32'(out_valid), 32'd0);
        chk("t6_hold_data", 32'(out_data), 32'h0001);
        chk("t6_hold_src", 32'(out_src), 32'd1);

        // Round-robin fairness from rr_ptr=0.
        mode = 1'b1; ch[1] = vals[1]; in_valid = 3'b111; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int g;
            g = i % 3;
            push(2'(g), vals[g]);
            #1 chk("t4_ready", 32'(in_ready), 32'(1 << g));
            step();
        end

        // Round-robin skip: set rr_ptr=1, then request only 0 and 2.
        in_valid = 3'b001;
        push(2'd0, vals[0]);
        step();
        in_valid = 3'b101;
        push(2'd2, vals[2]);
        #1 chk("t5_skip_ready", 32'(in_ready), 32'b100);
        step();
        push(2'd0, vals[0]);
        #1 chk("t5_wrap_ready", 32'(in_ready), 32'b001);
        step();
        in_valid = 3'b000;
        #1 chk("t5_none_ready", 32'(in_ready), 32'b000);
        step();
        chk("t5_drained", 32'(out_valid), 32'd0);
        chk("t5_hold_src", 32'(out_src), 32'd0);

        repeat (2) step();
        chk("sb_left_over", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
